// File: rtl/output_image_bank_if.sv
// rtl/output_image_bank_if.sv - output image bank bus interface
//
// Groups the core-side output bus and the device-side output pins of
// output_image_bank. The tri-state read-back pin is a separate top-level
// port of the bank and is not carried here.
//
// Signals:
//   OUTIMG_EN          bank select; gates writes and read-back drive
//   OUTIMG_WE          image write strobe
//   OUTIMG_OP[1:0]     00 write DATA, 01 set, 10 clear, 11 toggle
//   OUTIMG_ADDR        write bit address
//   OUTIMG_DATA        write data (OP=00 only)
//   OUTIMG_RD_ADDR     read-back bit address
//   OUTIMG_LOAD        transfer image to the output latch
//   OUTIMG_OUTPUT      physical output latch
//   OUTIMG_WD_TIMEOUT  watchdog idle-cycle limit, 0 disables
//   OUTIMG_FAULT_CLR   leave the watchdog fault state
//   OUTIMG_FAULT       watchdog tripped
//
// Modports: master drives the bus (core side), slave is the bank.

interface output_image_bank_if #(
  parameter int NUM_OUT = 16,
  parameter int ADDR_W  = 4,
  parameter int WD_W    = 16
) ();

  logic                OUTIMG_EN;
  logic                OUTIMG_WE;
  logic [1:0]          OUTIMG_OP;
  logic [ADDR_W-1:0]   OUTIMG_ADDR;
  logic                OUTIMG_DATA;
  logic [ADDR_W-1:0]   OUTIMG_RD_ADDR;
  logic                OUTIMG_LOAD;
  logic [NUM_OUT-1:0]  OUTIMG_OUTPUT;
  logic [WD_W-1:0]     OUTIMG_WD_TIMEOUT;
  logic                OUTIMG_FAULT_CLR;
  logic                OUTIMG_FAULT;

  modport master (
    output OUTIMG_EN, OUTIMG_WE, OUTIMG_OP, OUTIMG_ADDR, OUTIMG_DATA,
           OUTIMG_RD_ADDR, OUTIMG_LOAD, OUTIMG_WD_TIMEOUT, OUTIMG_FAULT_CLR,
    input  OUTIMG_OUTPUT, OUTIMG_FAULT
  );

  modport slave (
    input  OUTIMG_EN, OUTIMG_WE, OUTIMG_OP, OUTIMG_ADDR, OUTIMG_DATA,
           OUTIMG_RD_ADDR, OUTIMG_LOAD, OUTIMG_WD_TIMEOUT, OUTIMG_FAULT_CLR,
    output OUTIMG_OUTPUT, OUTIMG_FAULT
  );

endinterface

// File: rtl/output_image_bank.sv
// rtl/output_image_bank.sv - PLC output image bank with scan-cycle watchdog
//
// Cores update single image bits (write/set/clear/toggle); LOAD copies the
// image to the physical output latch. With OUTPUT_IMAGE_WATCHDOG_EN defined,
// a watchdog forces SAFE_STATE onto the outputs when LOADs stop arriving.
// Without it, OUTIMG_FAULT is 0, WD_TIMEOUT/FAULT_CLR are ignored and LOAD
// always transfers the image.
//
// Ports:
//   CLK             clock, rising edge
//   RST_N           asynchronous active-low reset
//   bus             output_image_bank_if.slave (bus + output pins)
//   OUTIMG_RD_DATA  image bit at OUTIMG_RD_ADDR, high-Z when OUTIMG_EN=0

module output_image_bank #(
  parameter int                 NUM_OUT    = 16,
  parameter int                 ADDR_W     = 4,
  parameter int                 WD_W       = 16,
  parameter logic [NUM_OUT-1:0] SAFE_STATE = {NUM_OUT{1'b0}}
) (
  input  logic               CLK,
  input  logic               RST_N,
  output_image_bank_if.slave bus,
  output wire                OUTIMG_RD_DATA
);

  // NUM_OUT may equal 2^ADDR_W, so compare in one extra bit.
  localparam logic [ADDR_W:0] LP_NUM_OUT = (ADDR_W+1)'(NUM_OUT);

  logic [NUM_OUT-1:0] r_image;
  logic [NUM_OUT-1:0] w_image_nxt;
  logic [NUM_OUT-1:0] r_output;
  logic               w_wr_ok;
  logic               w_rd_bit;
  logic               w_trip;
  logic               w_load_ok;

  assign w_wr_ok = bus.OUTIMG_EN & bus.OUTIMG_WE &
                   ({1'b0, bus.OUTIMG_ADDR} < LP_NUM_OUT);

  always_comb begin
    w_image_nxt = r_image;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (w_wr_ok && (bus.OUTIMG_ADDR == ADDR_W'(i))) begin
        case (bus.OUTIMG_OP)
          2'b00:   w_image_nxt[i] = bus.OUTIMG_DATA;
          2'b01:   w_image_nxt[i] = 1'b1;
          2'b10:   w_image_nxt[i] = 1'b0;
          default: w_image_nxt[i] = ~r_image[i];
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_image <= '0;
    end else begin
      r_image <= w_image_nxt;
    end
  end

  // Addresses at or above NUM_OUT match no bit and read 0.
  always_comb begin
    w_rd_bit = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (bus.OUTIMG_RD_ADDR == ADDR_W'(i)) begin
        w_rd_bit = r_image[i];
      end
    end
  end

  assign OUTIMG_RD_DATA = bus.OUTIMG_EN ? w_rd_bit : 1'bz;

`ifdef OUTPUT_IMAGE_WATCHDOG_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } wd_state_t;

  wd_state_t       r_state;
  wd_state_t       w_state_nxt;
  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_cnt_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_wd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wd_cnt <= w_wd_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wd_cnt_nxt = r_wd_cnt;
    w_trip       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wd_cnt_nxt = '0;
        if (bus.OUTIMG_LOAD) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // LOAD wins over the trip; the limit is compared live so lowering
        // it below the current count trips on the next idle edge.
        if (bus.OUTIMG_LOAD) begin
          w_wd_cnt_nxt = '0;
        end else if (bus.OUTIMG_WD_TIMEOUT == '0) begin
          w_wd_cnt_nxt = '0;
        end else if (r_wd_cnt >= bus.OUTIMG_WD_TIMEOUT) begin
          w_state_nxt = ST_FAULT;
          w_trip      = 1'b1;
        end else if (r_wd_cnt != {WD_W{1'b1}}) begin
          w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
        end
      end
      ST_FAULT: begin
        if (bus.OUTIMG_FAULT_CLR) begin
          w_state_nxt  = ST_IDLE;
          w_wd_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_wd_cnt_nxt = '0;
      end
    endcase
  end

  // In FAULT the latch already holds SAFE_STATE; ignoring LOAD keeps it there.
  assign w_load_ok        = bus.OUTIMG_LOAD & (r_state != ST_FAULT);
  assign bus.OUTIMG_FAULT = (r_state == ST_FAULT);
`else
  logic w_unused;

  assign w_unused         = ^{bus.OUTIMG_WD_TIMEOUT, bus.OUTIMG_FAULT_CLR};
  assign w_trip           = 1'b0;
  assign w_load_ok        = bus.OUTIMG_LOAD;
  assign bus.OUTIMG_FAULT = 1'b0;
`endif

  // LOAD samples the pre-edge image, so a same-cycle write lands next load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_output <= SAFE_STATE;
    end else if (w_trip) begin
      r_output <= SAFE_STATE;
    end else if (w_load_ok) begin
      r_output <= r_image;
    end
  end

  assign bus.OUTIMG_OUTPUT = r_output;

endmodule
